vga_timing_gen: RTL

- Generates the VGA raster timing that drives the pixel painter.
- Free-running horizontal and vertical counters produce pixel coordinates (`hdata`, `vdata`), sync pulses and a data-enable; the painter turns each coordinate into RGB.
- Sits between the pixel-clock domain and the painter/video output pins. Defaults are 800x600@72 Hz on a 50 MHz pixel clock.

---
 rtl/vga_pkg.sv | 13 +
 rtl/vga_axis_counter.sv | 48 ++++
 rtl/vga_timing_gen.sv | 71 +++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared coordinate type and default 800x600@72 timing constants
package vga_pkg;
  localparam int COORD_W = 12;
  typedef logic [COORD_W-1:0] coord_t;
  localparam int H_SIZE = 800;
  localparam int H_FP   = 856;
  localparam int H_SP   = 976;
  localparam int H_MAX  = 1040;
  localparam int V_SIZE = 600;
  localparam int V_FP   = 637;
  localparam int V_SP   = 643;
  localparam int V_MAX  = 666;
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (count, wrap, next-state active flag, registered sync)
// Ports: clk, rst_n (async, active-low), adv (advance enable);
//        count (current position), wrap (count is at MAX-1),
//        active_nxt (next position is inside the active area), sync (registered sync level)
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int SIZE       = H_SIZE,
  parameter int SYNC_START = H_FP,
  parameter int SYNC_END   = H_SP,
  parameter int MAX        = H_MAX,
  parameter bit POL        = 1'b1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   adv,
  output coord_t count,
  output logic   wrap,
  output logic   active_nxt,
  output logic   sync
);
  if (!(SIZE <= SYNC_START && SYNC_START <= SYNC_END && SYNC_END < MAX && MAX <= 4096)) begin : g_bad
    $fatal(1, "vga_axis_counter: illegal timing parameters");
  end
  localparam coord_t LAST = coord_t'(MAX - 1);
  localparam coord_t S_SZ = coord_t'(SIZE);
  localparam coord_t S_ST = coord_t'(SYNC_START);
  localparam coord_t S_EN = coord_t'(SYNC_END);
  coord_t count_q, count_d;
  logic   sync_q, sync_d;
  always_comb begin
    count_d    = adv ? (count_q == LAST ? '0 : count_q + coord_t'(1)) : count_q;
    active_nxt = count_d < S_SZ;
    sync_d     = (count_d >= S_ST && count_d < S_EN) ? POL : !POL;
  end
  // Reset parks on the last blanking position so the first advance lands on 0.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count_q <= LAST;
      sync_q  <= !POL;
    end else begin
      count_q <= count_d;
      sync_q  <= sync_d;
    end
  assign count = count_q;
  assign wrap  = count_q == LAST;
  assign sync  = sync_q;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing (coordinates, syncs, data enable, start pulses)
// Ports: clk, rst_n (async, active-low), pix_ce (pixel clock enable);
//        hdata/vdata (coordinates), hsync/vsync, data_enable, line_start, frame_start;
//        frame_cnt only when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int HSIZE = H_SIZE,
  parameter int HFP   = H_FP,
  parameter int HSP   = H_SP,
  parameter int HMAX  = H_MAX,
  parameter int VSIZE = V_SIZE,
  parameter int VFP   = V_FP,
  parameter int VSP   = V_SP,
  parameter int VMAX  = V_MAX,
  parameter int HSPP  = 1,
  parameter int VSPP  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_ce,
  output logic [11:0] hdata,
  output logic [11:0] vdata,
  output logic        hsync,
  output logic        vsync,
  output logic        data_enable,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic [15:0] frame_cnt,
`endif
  output logic        line_start,
  output logic        frame_start
);
  logic h_wrap, v_wrap, h_act, v_act;
  logic de_q, de_d, ls_q, ls_d, fs_q, fs_d;
  vga_axis_counter #(.SIZE(HSIZE), .SYNC_START(HFP), .SYNC_END(HSP), .MAX(HMAX), .POL(HSPP != 0)) u_h (
    .clk(clk), .rst_n(rst_n), .adv(pix_ce),
    .count(hdata), .wrap(h_wrap), .active_nxt(h_act), .sync(hsync)
  );
  // Vertical steps only as the line wraps, so vsync changes together with hdata=0.
  vga_axis_counter #(.SIZE(VSIZE), .SYNC_START(VFP), .SYNC_END(VSP), .MAX(VMAX), .POL(VSPP != 0)) u_v (
    .clk(clk), .rst_n(rst_n), .adv(pix_ce & h_wrap),
    .count(vdata), .wrap(v_wrap), .active_nxt(v_act), .sync(vsync)
  );
  always_comb begin
    de_d = h_act & v_act;
    ls_d = pix_ce ? h_wrap : ls_q;
    fs_d = pix_ce ? h_wrap & v_wrap : fs_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      de_q <= 1'b0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      de_q <= de_d;
      ls_q <= ls_d;
      fs_q <= fs_d;
    end
  assign data_enable = de_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
`ifdef VGA_TIMING_FRAME_CNT_EN
  // Starts at all-ones so entering the first frame reads 0.
  logic [15:0] fc_q, fc_d;
  always_comb fc_d = (pix_ce & h_wrap & v_wrap) ? fc_q + 16'd1 : fc_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fc_q <= 16'hFFFF;
    else fc_q <= fc_d;
  assign frame_cnt = fc_q;
`endif
endmodule
